// File: rtl/mult_accumulator.sv
// Saturating accumulator that sums a run of signed products from an upstream multiplier.
// It holds the final sum for a valid/ready consumer.
module mult_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int PROD_WIDTH = 2 * DATA_WIDTH,
  parameter int ACC_WIDTH  = 18,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic                         clear,
  input  logic signed [PROD_WIDTH-1:0] prod_in,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic                         ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH:0]          CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0]          CNT_FULL = {1'b1, {LEN_WIDTH{1'b0}}};

  logic [1:0]                  r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;
  logic [LEN_WIDTH:0]          r_cnt;
  logic [LEN_WIDTH-1:0]        r_len;

  logic                        w_accept;
  logic signed [ACC_WIDTH:0]   w_prod_ext;
  logic signed [ACC_WIDTH:0]   w_acc_ext;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic                        w_sat;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic [LEN_WIDTH:0]          w_cnt_inc;
  logic [LEN_WIDTH:0]          w_target;
  logic                        w_last;

  assign prod_ready = (r_state == S_ACCUM);
  assign out_valid  = (r_state == S_DONE);
  assign acc_out    = r_acc;
  assign ovf        = r_ovf;

  assign w_accept   = prod_ready && prod_valid;
  assign w_prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
  assign w_acc_ext  = {r_acc[ACC_WIDTH-1], r_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;

  // One guard bit is enough: the top two bits disagree exactly when the sum left the ACC range.
  assign w_sat      = (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]);
  assign w_acc_next = w_sat ? (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : w_sum[ACC_WIDTH-1:0];

  assign w_cnt_inc  = r_cnt + CNT_ONE;
  assign w_target   = (r_len == '0) ? CNT_FULL : {1'b0, r_len};
  assign w_last     = (w_cnt_inc == w_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Result stays in r_acc after release so it is still readable from IDLE.
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand width of the upstream multiplier.
REQ-002 Parameter PROD_WIDTH, default 2*DATA_WIDTH: signed product width consumed.
REQ-003 Parameter ACC_WIDTH, default 18: signed accumulator/result width, ACC_WIDTH > PROD_WIDTH.
REQ-004 Parameter LEN_WIDTH, default 4: width of the term-count input.
REQ-005 The design has one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-009 len  input  LEN_WIDTH  number of terms, latched on start; 0 means 2^LEN_WIDTH.
REQ-010 clear  input  1  synchronous abort to IDLE.
REQ-011 prod_in  input  PROD_WIDTH  signed product from the multiplier.
REQ-012 prod_valid  input  1  prod_in is valid.
REQ-013 prod_ready  output  1  block accepts a product this cycle.
REQ-014 acc_out  output  ACC_WIDTH  signed saturated sum.
REQ-015 ovf  output  1  sticky saturation flag for the current run.
REQ-016 out_valid  output  1  acc_out/ovf hold a final result.
REQ-017 out_ready  input  1  consumer accepts the result.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-019 IDLE: prod_ready=0 and out_valid=0; on start, latch len, zero the accumulator, clear ovf and the term counter, then go to ACCUM next cycle.
REQ-020 ACCUM: prod_ready=1; a product is accepted when prod_valid&&prod_ready at a rising edge.
REQ-021 Each accepted product SHALL be sign-extended to ACC_WIDTH+1 bits and added to the accumulator.
REQ-022 A sum above 2^(ACC_WIDTH-1)-1 SHALL clamp to that value, and a sum below -2^(ACC_WIDTH-1) SHALL clamp to that value; either clamp sets ovf.
REQ-023 ovf SHALL stay set until the next start or reset.
REQ-024 No accept cycle: accumulator, counter and ovf hold.
REQ-025 The cycle that accepts the final term, where counter equals latched len with 0 meaning 2^LEN_WIDTH, SHALL transition to DONE.
REQ-026 out_valid SHALL assert on the next cycle, giving one-cycle latency after the last accept.
REQ-027 DONE: out_valid=1 and prod_ready=0; acc_out and ovf are stable.
REQ-028 In DONE, out_valid&&out_ready SHALL return the FSM to IDLE next cycle; acc_out keeps its value until the next start.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 clear in any state SHALL go to IDLE next cycle, zero acc_out and ovf, and override start, accept and out_ready in the same cycle.
REQ-031 start and clear asserted together in IDLE: clear wins and the block stays in IDLE.
REQ-032 The term counter SHALL be LEN_WIDTH+1 bits so a count of 2^LEN_WIDTH does not wrap.

Reset
REQ-033 rst=1 SHALL immediately, without a clock, force IDLE and set acc_out=0, ovf=0, out_valid=0, prod_ready=0, counter=0, latched len=0.
REQ-034 rst asserted mid-ACCUM or in DONE SHALL discard the partial result; after release the block waits in IDLE for start.

Verification
REQ-035 Reset: assert rst asynchronously between clock edges -> all outputs 0 within the same timestep, state IDLE.
REQ-036 Basic run: start with len=3, feed prod_in=-735 (-21*35) three consecutive cycles -> out_valid one cycle after the third accept, acc_out=-2205 (18'h3F763), ovf=0.
REQ-037 Saturation: start with len=0, feed 16 products of 16384 -> acc_out=131071, ovf=1.
REQ-037a Negative saturation: repeat with -16384 -> acc_out=-131072, ovf=1.
REQ-038 Backpressure/gaps: start with len=2, prod_valid toggling 1,0,0,1 with values 100 and -40 -> acc_out=60.
REQ-038a With out_ready held 0 for 5 cycles -> out_valid and acc_out=60 stay stable, and IDLE follows out_ready=1.
REQ-039 Abort: clear after 2 of 4 accepts -> IDLE, acc_out=0.
REQ-039a A start pulse during ACCUM or DONE is ignored, and a following start with len=1 and product 7 -> acc_out=7.
REQ-040 Mid-run reset: rst pulse during ACCUM after 1 accept -> outputs 0, and a subsequent len=1 run with product -1 -> acc_out=-1.
